// File: rtl/mem_stack_unit.sv
// Data-memory and stack sequencer: one req/ack transaction per LD/ST/PUSH/POP, owns SP, stalls the pipe.
// Defining MEM_TIMEOUT_EN adds a REQ watchdog (parameter TIMEOUT) that aborts an unacknowledged transfer.
module mem_stack_unit #(
  parameter int                DATA_W  = 16,
  parameter int                ADDR_W  = 16,
  parameter logic [ADDR_W-1:0] SP_INIT = 16'h0000
`ifdef MEM_TIMEOUT_EN
  ,
  parameter int                TIMEOUT = 64
`endif
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              memrd,
  input  logic              memwr,
  input  logic              SPwe,
  input  logic              MemInSel,
  input  logic [ADDR_W-1:0] alu_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic              stall,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic [ADDR_W-1:0] sp,
  output logic              err,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [1:0]        dbg_state
);

  // Memory handshake: mem_req rises the cycle after a command is accepted and stays high,
  // with mem_addr/mem_we/mem_wdata stable, until a cycle in which mem_ack is high; the
  // transfer completes on that clock edge. mem_ack (and mem_rdata) outside REQ is ignored.

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [ADDR_W-1:0] SP_STEP = 1;

  state_t            r_state;
  state_t            w_next_state;

  logic [ADDR_W-1:0] r_sp;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic              r_we;
  logic              r_is_rd;
  logic              r_is_push;
  logic              r_is_pop;
  logic [DATA_W-1:0] r_rd_data;
  logic              r_rd_valid;
  logic              r_err;

  logic              w_ld;
  logic              w_st;
  logic              w_push;
  logic              w_pop;
  logic              w_illegal;
  logic              w_legal;
  logic [ADDR_W-1:0] w_cmd_addr;
  logic              w_tmo;

  // memwr & SPwe & !MemInSel decodes to no class and is dropped like a bare SPwe.
  always_comb begin
    w_illegal  = memrd & memwr;
    w_ld       = memrd & ~memwr & ~SPwe;
    w_st       = memwr & ~memrd & ~SPwe;
    w_push     = memwr & ~memrd & SPwe & MemInSel;
    w_pop      = memrd & ~memwr & SPwe;
    w_legal    = w_ld | w_st | w_push | w_pop;
    w_cmd_addr = alu_addr;
    if (w_push)
      w_cmd_addr = r_sp - SP_STEP;
    else if (w_pop)
      w_cmd_addr = r_sp;
  end

`ifdef MEM_TIMEOUT_EN
  localparam int            TW       = $clog2(TIMEOUT);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

  logic [TW-1:0] r_tmo_cnt;

  // Counts REQ cycles without ack; held at zero outside REQ so every entry starts fresh.
  always_ff @(posedge clk) begin
    if (rst || (r_state != S_REQ))
      r_tmo_cnt <= '0;
    else if (!mem_ack)
      r_tmo_cnt <= r_tmo_cnt + 1'b1;
  end

  assign w_tmo = (r_state == S_REQ) & ~mem_ack & (r_tmo_cnt == TMO_LAST);
`else
  assign w_tmo = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst)
      r_state <= S_IDLE;
    else
      r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE: if (w_legal) w_next_state = S_REQ;
      S_REQ:  if (mem_ack || w_tmo) w_next_state = S_DONE;
      S_DONE: w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  always_comb begin
    mem_req   = (r_state == S_REQ);
    stall     = ((r_state == S_IDLE) & w_legal) | (r_state == S_REQ);
    dbg_state = r_state;
  end

  // SP and read data are written on the ack edge so they are already visible in DONE.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sp       <= SP_INIT;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_we       <= 1'b0;
      r_is_rd    <= 1'b0;
      r_is_push  <= 1'b0;
      r_is_pop   <= 1'b0;
      r_rd_data  <= '0;
      r_rd_valid <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_rd_valid <= 1'b0;
      r_err      <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_err <= w_illegal;
          if (w_legal) begin
            r_addr    <= w_cmd_addr;
            r_wdata   <= wr_data;
            r_we      <= w_st | w_push;
            r_is_rd   <= w_ld | w_pop;
            r_is_push <= w_push;
            r_is_pop  <= w_pop;
          end
        end
        S_REQ: begin
          if (mem_ack) begin
            if (r_is_rd) begin
              r_rd_data  <= mem_rdata;
              r_rd_valid <= 1'b1;
            end
            if (r_is_push)
              r_sp <= r_sp - SP_STEP;
            else if (r_is_pop)
              r_sp <= r_sp + SP_STEP;
          end else if (w_tmo) begin
            r_err <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign sp        = r_sp;
  assign rd_data   = r_rd_data;
  assign rd_valid  = r_rd_valid;
  assign err       = r_err;
  assign mem_we    = r_we;
  assign mem_addr  = r_addr;
  assign mem_wdata = r_wdata;

endmodule

// File: tb/tb_mem_stack_unit.sv
// Bench for mem_stack_unit: vector table of memory ops with a read-data scoreboard, plus
// hand sequences for illegal commands, ignored SPwe, reset during REQ and (optionally) timeout.
module tb_mem_stack_unit;

  localparam int DATA_W = 16;
  localparam int ADDR_W = 16;

  logic              clk = 1'b0;
  logic              rst;
  logic              memrd, memwr, SPwe, MemInSel;
  logic [ADDR_W-1:0] alu_addr;
  logic [DATA_W-1:0] wr_data;
  logic              stall;
  logic [DATA_W-1:0] rd_data;
  logic              rd_valid;
  logic [ADDR_W-1:0] sp;
  logic              err;
  logic              mem_req, mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_ack;
  logic [DATA_W-1:0] mem_rdata;
  logic [1:0]        dbg_state;

  mem_stack_unit #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .SP_INIT(16'h0000)
`ifdef MEM_TIMEOUT_EN
    ,
    .TIMEOUT(4)
`endif
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .memrd    (memrd),
    .memwr    (memwr),
    .SPwe     (SPwe),
    .MemInSel (MemInSel),
    .alu_addr (alu_addr),
    .wr_data  (wr_data),
    .stall    (stall),
    .rd_data  (rd_data),
    .rd_valid (rd_valid),
    .sp       (sp),
    .err      (err),
    .mem_req  (mem_req),
    .mem_we   (mem_we),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .mem_ack  (mem_ack),
    .mem_rdata(mem_rdata),
    .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
    end
  endtask

  // Scoreboard: expected read data queued when a read command is driven, popped on rd_valid.
  logic [DATA_W-1:0] exp_q[$];
  logic [DATA_W-1:0] sb_exp;

  always @(negedge clk) begin
    if (rd_valid === 1'b1) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL sb_unexpected_rd_valid: got rd_data %0h, expected no rd_valid", rd_data);
      end else begin
        sb_exp = exp_q.pop_front();
        if (rd_data !== sb_exp) begin
          n_fail++;
          $display("FAIL sb_rd_data: got %0h, expected %0h", rd_data, sb_exp);
        end
      end
    end
  end

  // ---------------- driver ----------------
  typedef struct {
    logic              rd;
    logic              wr;
    logic              spwe;
    logic              misel;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    int                ack_dly;   // REQ cycles including the ack cycle (>= 1)
    logic [DATA_W-1:0] rdata;
    logic [ADDR_W-1:0] exp_addr;
    logic              exp_we;
    logic [ADDR_W-1:0] exp_sp;
  } vec_t;

  function automatic vec_t mk(input logic rd, input logic wr, input logic spwe, input logic misel,
                              input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] wdata,
                              input int ack_dly, input logic [DATA_W-1:0] rdata,
                              input logic [ADDR_W-1:0] exp_addr, input logic exp_we,
                              input logic [ADDR_W-1:0] exp_sp);
    vec_t v;
    v.rd = rd; v.wr = wr; v.spwe = spwe; v.misel = misel;
    v.addr = addr; v.wdata = wdata; v.ack_dly = ack_dly; v.rdata = rdata;
    v.exp_addr = exp_addr; v.exp_we = exp_we; v.exp_sp = exp_sp;
    return v;
  endfunction

  task automatic clear_cmd();
    memrd = 1'b0; memwr = 1'b0; SPwe = 1'b0; MemInSel = 1'b0;
    alu_addr = ADDR_W'($urandom); wr_data = DATA_W'($urandom);
  endtask

  task automatic run_op(input vec_t v, input int idx);
    @(posedge clk); #1;
    memrd = v.rd; memwr = v.wr; SPwe = v.spwe; MemInSel = v.misel;
    alu_addr = v.addr; wr_data = v.wdata;
    if (v.rd) exp_q.push_back(v.rdata);
    @(negedge clk);
    check($sformatf("v%0d stall_accept", idx), stall, 1);
    check($sformatf("v%0d req_accept", idx), mem_req, 0);
    @(posedge clk); #1;
    clear_cmd();
    for (int k = 1; k <= v.ack_dly; k++) begin
      if (k == v.ack_dly) begin
        mem_ack = 1'b1; mem_rdata = v.rdata;
      end else begin
        mem_rdata = DATA_W'($urandom);
      end
      @(negedge clk);
      check($sformatf("v%0d req_c%0d", idx, k), mem_req, 1);
      check($sformatf("v%0d we_c%0d", idx, k), mem_we, v.exp_we);
      check($sformatf("v%0d addr_c%0d", idx, k), mem_addr, v.exp_addr);
      if (v.exp_we) check($sformatf("v%0d wdata_c%0d", idx, k), mem_wdata, v.wdata);
      check($sformatf("v%0d stall_c%0d", idx, k), stall, 1);
      @(posedge clk); #1;
      mem_ack = 1'b0;
    end
    @(negedge clk);
    check($sformatf("v%0d done_stall", idx), stall, 0);
    check($sformatf("v%0d done_req", idx), mem_req, 0);
    check($sformatf("v%0d done_rd_valid", idx), rd_valid, v.rd);
    check($sformatf("v%0d done_sp", idx), sp, v.exp_sp);
    check($sformatf("v%0d done_err", idx), err, 0);
    if (v.rd) check($sformatf("v%0d done_rd_data", idx), rd_data, v.rdata);
  endtask

  // ---------------- test ----------------
  vec_t vecs[10];
  logic [ADDR_W-1:0] r_addr_rand;
  logic [DATA_W-1:0] r_data_rand;

  initial begin
    r_addr_rand = ADDR_W'($urandom_range(16'h0100, 16'hEFFF));
    r_data_rand = DATA_W'($urandom_range(1, 16'hFFFF));
    //           rd    wr    spwe  misel addr        wdata        dly rdata     exp_addr    we    exp_sp
    vecs[0] = mk(1'b0, 1'b1, 1'b0, 1'b0, 16'h0040,   16'hBEEF,    3, 16'h0000, 16'h0040,   1'b1, 16'h0000);
    vecs[1] = mk(1'b1, 1'b0, 1'b0, 1'b0, 16'h0040,   16'h0000,    1, 16'hBEEF, 16'h0040,   1'b0, 16'h0000);
    vecs[2] = mk(1'b0, 1'b1, 1'b1, 1'b1, 16'h0123,   16'h1234,    1, 16'h0000, 16'hFFFF,   1'b1, 16'hFFFF);
    vecs[3] = mk(1'b0, 1'b1, 1'b1, 1'b1, 16'h0456,   16'h5678,    2, 16'h0000, 16'hFFFE,   1'b1, 16'hFFFE);
    vecs[4] = mk(1'b1, 1'b0, 1'b1, 1'b0, 16'h0789,   16'h0000,    1, 16'h5678, 16'hFFFE,   1'b0, 16'hFFFF);
    vecs[5] = mk(1'b1, 1'b0, 1'b1, 1'b1, 16'h0ABC,   16'h0000,    3, 16'h1234, 16'hFFFF,   1'b0, 16'h0000);
    vecs[6] = mk(1'b1, 1'b0, 1'b0, 1'b0, 16'h1234,   16'h0000,    2, 16'hA5A5, 16'h1234,   1'b0, 16'h0000);
    vecs[7] = mk(1'b1, 1'b0, 1'b1, 1'b0, 16'h2222,   16'h0000,    1, 16'h0F0F, 16'h0000,   1'b0, 16'h0001);
    vecs[8] = mk(1'b0, 1'b1, 1'b1, 1'b1, 16'h3333,   16'hC3C3,    1, 16'h0000, 16'h0000,   1'b1, 16'h0000);
    vecs[9] = mk(1'b0, 1'b1, 1'b0, 1'b0, r_addr_rand, r_data_rand, 2, 16'h0000, r_addr_rand, 1'b1, 16'h0000);

    rst = 1'b1; mem_ack = 1'b0; mem_rdata = '0;
    memrd = 1'b0; memwr = 1'b0; SPwe = 1'b0; MemInSel = 1'b0; alu_addr = '0; wr_data = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst stall", stall, 0);
    check("rst rd_data", rd_data, 0);
    check("rst rd_valid", rd_valid, 0);
    check("rst sp", sp, 16'h0000);
    check("rst err", err, 0);
    check("rst mem_req", mem_req, 0);
    check("rst mem_we", mem_we, 0);
    check("rst mem_addr", mem_addr, 0);
    check("rst mem_wdata", mem_wdata, 0);
    check("rst state", dbg_state, 0);
    @(posedge clk); #1;
    rst = 1'b0;

    for (int i = 0; i < 10; i++) run_op(vecs[i], i);

    // Illegal memrd & memwr: one err pulse, no transaction, no stall.
    @(posedge clk); #1;
    memrd = 1'b1; memwr = 1'b1; SPwe = 1'b0; alu_addr = 16'h0050;
    @(negedge clk);
    check("ill stall", stall, 0);
    @(posedge clk); #1;
    clear_cmd();
    @(negedge clk);
    check("ill err_pulse", err, 1);
    check("ill mem_req", mem_req, 0);
    check("ill stall2", stall, 0);
    @(negedge clk);
    check("ill err_clear", err, 0);
    check("ill mem_req2", mem_req, 0);
    check("ill state", dbg_state, 0);

    // Bare SPwe is ignored.
    @(posedge clk); #1;
    SPwe = 1'b1; MemInSel = 1'b1;
    @(negedge clk);
    check("spwe stall", stall, 0);
    @(posedge clk); #1;
    clear_cmd();
    @(negedge clk);
    check("spwe mem_req", mem_req, 0);
    check("spwe err", err, 0);
    check("spwe sp", sp, 16'h0000);

    // Reset during REQ, late ack afterwards.
    run_op(mk(1'b0, 1'b1, 1'b1, 1'b1, 16'h0000, 16'h7777, 1, 16'h0000, 16'hFFFF, 1'b1, 16'hFFFF), 20);
    @(posedge clk); #1;
    memrd = 1'b1; alu_addr = 16'h0200;
    @(posedge clk); #1;
    clear_cmd();
    @(negedge clk);
    check("rstreq mem_req_before", mem_req, 1);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; mem_ack = 1'b1; mem_rdata = 16'hDEAD;
    @(negedge clk);
    check("rstreq mem_req", mem_req, 0);
    check("rstreq sp", sp, 16'h0000);
    check("rstreq stall", stall, 0);
    check("rstreq state", dbg_state, 0);
    @(posedge clk); #1;
    mem_ack = 1'b0;
    @(negedge clk);
    check("rstreq rd_valid", rd_valid, 0);
    check("rstreq mem_req2", mem_req, 0);
    check("rstreq state2", dbg_state, 0);

`ifdef MEM_TIMEOUT_EN
    // LD with no ack: four REQ cycles, then DONE with err and no data.
    @(posedge clk); #1;
    memrd = 1'b1; alu_addr = 16'h0100;
    @(posedge clk); #1;
    clear_cmd();
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      check($sformatf("tmo req_c%0d", k), mem_req, 1);
      check($sformatf("tmo err_c%0d", k), err, 0);
    end
    @(negedge clk);
    check("tmo err_pulse", err, 1);
    check("tmo rd_valid", rd_valid, 0);
    check("tmo mem_req", mem_req, 0);
    check("tmo sp", sp, 16'h0000);
    @(negedge clk);
    check("tmo err_clear", err, 0);
    check("tmo mem_req2", mem_req, 0);
    // Ack on the last allowed cycle still succeeds.
    run_op(mk(1'b1, 1'b0, 1'b0, 1'b0, 16'h0104, 16'h0000, 4, 16'h4242, 16'h0104, 1'b0, 16'h0000), 30);
`endif

    repeat (2) @(posedge clk);
    check("sb queue_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
